pipe_wb_skid: RTL
=================

PIPE_WB_SKID -- requirements
Module: pipe_wb_skid

Interface
REQ-001 Parameter DW, default 32, width of the memory-data and ALU-result fields SHALL be DW bits.
REQ-002 Parameter RW, default 5, width of the destination register number SHALL be RW bits.
REQ-003 Parameter ZERO_SUPPRESS, default 1, SHALL force the write-enable to 0 for entries whose register number is 0 when set.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 m_valid  input  1  MEM stage offers an entry.
REQ-008 m_ready  output  1  block can accept an entry this cycle.
REQ-009 mwreg, mm2reg  input  1 each  register-write and load-select controls.
REQ-010 mmo, malu  input  DW each  memory read data and ALU result.
REQ-011 mrn  input  RW  destination register number.
REQ-012 w_valid  output  1  WB entry present on outputs.
REQ-013 w_ready  input  1  WB stage consumes the entry.
REQ-014 wwreg, wm2reg  output  1 each  held controls; wwreg SHALL be 0 whenever w_valid=0.
REQ-015 wmo, walu  output  DW each  held data fields.
REQ-016 wrn  output  RW  held register number.
REQ-017 wres  output  DW  write-back value: wmo if wm2reg=1, else walu (combinational from held state).
REQ-018 occ  output  2  number of held entries (0..2).

Function
REQ-019 Storage SHALL be two entries: main (drives all w* outputs) and skid; each entry holds wreg, m2reg, mo, alu, rn plus a valid bit.
REQ-020 m_ready SHALL equal NOT skid-valid, taken directly from a register (no combinational path from w_ready).
REQ-021 Accept SHALL occur when m_valid=1 and m_ready=1; emit SHALL occur when w_valid=1 and w_ready=1.
REQ-022 w_valid SHALL equal main-valid; occ SHALL equal main-valid + skid-valid.
REQ-023 occ=0, accept: entry loads main; occ becomes 1; w_valid high next cycle (latency 1).
REQ-024 occ=1, accept and emit: main loads the new entry; occ stays 1.
REQ-025 occ=1, accept, no emit: new entry loads skid; occ becomes 2; m_ready low next cycle.
REQ-026 occ=1, emit, no accept: main clears; occ becomes 0.
REQ-027 occ=2, emit: skid moves to main, skid clears; occ becomes 1 (accept impossible, m_ready=0).
REQ-028 occ=2, no emit: all state holds; outputs stable.
REQ-029 Entries SHALL leave in acceptance order; none duplicated or lost.
REQ-030 With ZERO_SUPPRESS=1, the stored wreg SHALL be mwreg AND (mrn != 0); with 0, stored as given.
REQ-031 flush=1 SHALL clear both valid bits and data fields to 0; an accept in the same cycle SHALL be discarded; m_ready SHALL be 1 the following cycle.
REQ-032 Priority SHALL be reset > flush > accept/emit.

Reset
REQ-033 reset=1 at a rising edge SHALL set w_valid=0, occ=0, m_ready=1, wwreg=0, wm2reg=0, wmo=0, walu=0, wrn=0, wres=0, and clear the skid entry.
REQ-034 reset asserted mid-operation (any occ) SHALL discard all entries in that cycle regardless of m_valid, w_ready, flush.

Verification
REQ-035 Reset then m_valid=1, mwreg=1, mrn=3, malu=0x00000010, w_ready=1 -> next cycle w_valid=1, wwreg=1, wrn=3, wres=0x00000010, occ=1.
REQ-036 w_ready=0, accept A (malu=0x1) then B (malu=0x2) -> occ=2, m_ready=0, outputs show A; raise w_ready -> A then B emitted on successive cycles, occ 2->1->0.
REQ-037 mm2reg=1, mmo=0xDEADBEEF, malu=0x12345678 -> wres=0xDEADBEEF; mm2reg=0 -> wres=0x12345678.
REQ-038 mwreg=1, mrn=0, ZERO_SUPPRESS=1 -> wwreg=0 with w_valid=1; same with ZERO_SUPPRESS=0 -> wwreg=1.
REQ-039 occ=2, flush=1 with m_valid=1 -> next cycle occ=0, w_valid=0, m_ready=1, wmo=walu=0.
REQ-040 occ=2, reset=1 with flush=0, w_ready=1 -> next cycle all outputs at REQ-033 values.

Source files
------------

// File: rtl/pipe_wb_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_wb_skid
// Description : Two-entry MEM->WB skid register with registered m_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_wb_skid #(
    parameter int DW            = 32,
    parameter int RW            = 5,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          m_valid,
    output logic          m_ready,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic [DW-1:0] mmo,
    input  logic [DW-1:0] malu,
    input  logic [RW-1:0] mrn,
    output logic          w_valid,
    input  logic          w_ready,
    output logic          wwreg,
    output logic          wm2reg,
    output logic [DW-1:0] wmo,
    output logic [DW-1:0] walu,
    output logic [RW-1:0] wrn,
    output logic [DW-1:0] wres,
    output logic [1:0]    occ
);

    // Entry layout: {wreg, m2reg, mo, alu, rn}
    localparam int C_EW = 2 + 2 * DW + RW;

    logic [C_EW-1:0] r_main;
    logic [C_EW-1:0] r_skid;
    logic            r_main_vld;
    logic            r_skid_vld;

    logic            w_in_wreg;
    logic [C_EW-1:0] w_in_entry;
    logic            w_accept;
    logic            w_emit;
    logic            w_main_wreg;

    generate
        if (ZERO_SUPPRESS != 0) begin : g_zero_suppress
            assign w_in_wreg = mwreg & (mrn != '0);
        end else begin : g_no_zero_suppress
            assign w_in_wreg = mwreg;
        end
    endgenerate

    assign w_in_entry = {w_in_wreg, mm2reg, mmo, malu, mrn};
    assign w_accept   = m_valid & ~r_skid_vld;
    assign w_emit     = r_main_vld & w_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_main     <= '0;
            r_skid     <= '0;
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else begin
            r_main_vld <= r_skid_vld | w_accept | (r_main_vld & ~w_ready);
            if (w_emit && r_skid_vld) begin
                // Full: accept is blocked, skid entry advances into main
                r_main     <= r_skid;
                r_skid     <= '0;
                r_skid_vld <= 1'b0;
            end else if (w_accept && (!r_main_vld || w_emit)) begin
                r_main <= w_in_entry;
            end else if (w_accept) begin
                r_skid     <= w_in_entry;
                r_skid_vld <= 1'b1;
            end
        end
    end

    assign {w_main_wreg, wm2reg, wmo, walu, wrn} = r_main;

    assign wwreg   = w_main_wreg & r_main_vld;
    assign wres    = wm2reg ? wmo : walu;
    assign w_valid = r_main_vld;
    assign m_ready = ~r_skid_vld;
    assign occ     = {1'b0, r_main_vld} + {1'b0, r_skid_vld};

endmodule
`default_nettype wire
